// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, frame FSM state type and parity helper for the
// PS/2 keyboard receiver. No ports; imported by the interface and modules.
package ps2_pkg;

    localparam logic [7:0] PREFIX_RELEASE = 8'hF0;
    localparam logic [7:0] PREFIX_EXT     = 8'hE0;
    localparam int         KC_W           = 10;
    localparam int         KC_REL_BIT     = 9;
    localparam int         KC_EXT_BIT     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: valid/ready key-code stream.
//   kc_data  : {released, extended, scan[7:0]} at the FIFO head
//   kc_valid : head entry present
//   kc_ready : consumer accepts kc_data when kc_valid & kc_ready
// master = key-code producer (receiver), slave = consumer.
interface ps2_keyboard_rx_if;
    import ps2_pkg::*;

    logic [KC_W-1:0] kc_data;
    logic            kc_valid;
    logic            kc_ready;

    modport master (output kc_data, output kc_valid, input kc_ready);
    modport slave  (input kc_data, input kc_valid, output kc_ready);

endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: brings one raw asynchronous PS/2 line into the clk domain
// through a 2-FF synchroniser, then only lets the filtered output follow the
// line once DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
//   clk, reset : system clock, synchronous active-high reset
//   raw        : asynchronous PS/2 line
//   filt       : filtered line, idles at 1 after reset
module ps2_line_filter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] stable_cnt_r;

    // Synchronise the raw line and count how long it has disagreed with filt.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r      <= 1'b1;
            sync2_r      <= 1'b1;
            stable_cnt_r <= {CW{1'b0}};
            filt         <= 1'b1;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            if (sync2_r != filt) begin
                // This sample is the DEBOUNCE_CYCLES-th disagreeing one in a row.
                if (stable_cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt         <= sync2_r;
                    stable_cnt_r <= {CW{1'b0}};
                end else begin
                    stable_cnt_r <= stable_cnt_r + CW'(1'b1);
                end
            end else begin
                stable_cnt_r <= {CW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: fully synchronous PS/2 keyboard receiver. Filters both PS/2
// lines, frames 11-bit characters (start, 8 data LSB first, odd parity, stop)
// with a per-bit timeout, folds E0/F0 prefixes into a 10-bit key code,
// optionally suppresses typematic repeats and buffers codes in a FWFT FIFO.
//   clk, reset        : system clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw asynchronous PS/2 lines
//   kc                : key-code stream (master side)
//   fifo_count        : entries currently held
//   err_parity        : one-cycle pulse, parity error
//   err_frame         : one-cycle pulse, bad stop bit or bit timeout
//   err_overflow      : one-cycle pulse, code dropped because FIFO full
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 200000,
    parameter int FIFO_DEPTH      = 8,
    parameter int FILTER_REPEAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_keyboard_rx_if.master           kc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        err_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- line filtering ----------------
    logic clk_filt_s;
    logic data_filt_s;
    logic clk_prev_r;
    logic fall_s;

    ps2_line_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .filt  (clk_filt_s)
    );

    ps2_line_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_data),
        .filt  (data_filt_s)
    );

    // Remember the previous filtered clock level for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_r <= 1'b1;
        end else begin
            clk_prev_r <= clk_filt_s;
        end
    end

    assign fall_s = clk_prev_r & ~clk_filt_s;

    // ---------------- frame FSM ----------------
    ps2_state_e    state_r;
    logic [2:0]    bitcnt_r;
    logic [7:0]    shift_r;
    logic          parity_r;
    logic [TW-1:0] tcnt_r;
    logic          byte_strobe_r;
    logic [7:0]    byte_r;

    // Frame the character on filtered clock falls; the timeout runs between falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            bitcnt_r      <= 3'd0;
            shift_r       <= 8'h00;
            parity_r      <= 1'b0;
            tcnt_r        <= {TW{1'b0}};
            byte_strobe_r <= 1'b0;
            byte_r        <= 8'h00;
            err_parity    <= 1'b0;
            err_frame     <= 1'b0;
        end else begin
            byte_strobe_r <= 1'b0;
            err_parity    <= 1'b0;
            err_frame     <= 1'b0;
            if (fall_s) begin
                tcnt_r <= {TW{1'b0}};
                case (state_r)
                    IDLE: begin
                        // A high start bit is line noise; ignore it silently.
                        if (!data_filt_s) begin
                            state_r  <= DATA;
                            bitcnt_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r  <= {data_filt_s, shift_r[7:1]};
                        bitcnt_r <= bitcnt_r + 3'd1;
                        if (bitcnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    PARITY: begin
                        parity_r <= data_filt_s;
                        state_r  <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit outranks a parity failure.
                        if (!data_filt_s) begin
                            err_frame <= 1'b1;
                        end else if (odd_parity_ok(shift_r, parity_r)) begin
                            byte_strobe_r <= 1'b1;
                            byte_r        <= shift_r;
                        end else begin
                            err_parity <= 1'b1;
                        end
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end else if (state_r != IDLE) begin
                if (tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_r   <= IDLE;
                    err_frame <= 1'b1;
                    tcnt_r    <= {TW{1'b0}};
                end else begin
                    tcnt_r <= tcnt_r + TW'(1'b1);
                end
            end else begin
                tcnt_r <= {TW{1'b0}};
            end
        end
    end

    // ---------------- prefix decoder and repeat filter ----------------
    logic            rel_r;
    logic            ext_r;
    logic [8:0]      last_make_r;
    logic            push_r;
    logic [KC_W-1:0] push_data_r;
    logic [KC_W-1:0] code_s;
    logic [8:0]      make_s;

    // Assemble the candidate key code from the pending prefix flags.
    always_comb begin
        code_s             = {2'b00, byte_r};
        code_s[KC_REL_BIT] = rel_r;
        code_s[KC_EXT_BIT] = ext_r;
        make_s             = {ext_r, byte_r};
    end

    // Fold prefixes into the code and decide whether it is pushed one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            rel_r       <= 1'b0;
            ext_r       <= 1'b0;
            last_make_r <= 9'h000;
            push_r      <= 1'b0;
            push_data_r <= {KC_W{1'b0}};
        end else begin
            push_r <= 1'b0;
            if (err_parity || err_frame) begin
                // A corrupted byte may have been the key a prefix belonged to.
                rel_r <= 1'b0;
                ext_r <= 1'b0;
            end else if (byte_strobe_r) begin
                case (byte_r)
                    PREFIX_RELEASE: rel_r <= 1'b1;
                    PREFIX_EXT:     ext_r <= 1'b1;
                    8'h00, 8'hFF: begin
                        rel_r <= 1'b0;
                        ext_r <= 1'b0;
                    end
                    default: begin
                        rel_r       <= 1'b0;
                        ext_r       <= 1'b0;
                        push_data_r <= code_s;
                        if (FILTER_REPEAT == 0) begin
                            push_r <= 1'b1;
                        end else if (rel_r) begin
                            push_r <= 1'b1;
                            if (last_make_r == make_s) begin
                                last_make_r <= 9'h000;
                            end
                        end else if (last_make_r != make_s) begin
                            push_r      <= 1'b1;
                            last_make_r <= make_s;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- key-code FIFO ----------------
    logic [KC_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic            kc_valid_r;
    logic [KC_W-1:0] kc_data_r;
    logic            full_s;
    logic            pop_s;
    logic            wr_en_s;
    logic [AW-1:0]   rd_next_s;
    logic [CW-1:0]   count_next_s;
    logic [KC_W-1:0] head_next_s;

    assign full_s  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop_s   = kc_valid_r & kc.kc_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr_en_s = push_r & (~full_s | pop_s);

    // Next read pointer, occupancy and head word so kc_data can be registered.
    always_comb begin
        rd_next_s    = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
        count_next_s = fifo_count + CW'(wr_en_s) - CW'(pop_s);
        if (count_next_s == {CW{1'b0}}) begin
            head_next_s = {KC_W{1'b0}};
        end else if (wr_en_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = push_data_r;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array; write only, contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_r;
        end
    end

    // Pointers, occupancy, registered head and overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            fifo_count   <= {CW{1'b0}};
            kc_valid_r   <= 1'b0;
            kc_data_r    <= {KC_W{1'b0}};
            err_overflow <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r     <= rd_next_s;
            fifo_count   <= count_next_s;
            kc_valid_r   <= (count_next_s != {CW{1'b0}});
            kc_data_r    <= head_next_s;
            err_overflow <= push_r & full_s & ~pop_s;
        end
    end

    assign kc.kc_valid = kc_valid_r;
    assign kc.kc_data  = kc_data_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: table of frames with expected codes
// and error pulses, plus sequences for timeout, overflow and mid-frame reset.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_raw = 1'b1;
    logic       ps2_data_raw = 1'b1;
    logic [2:0] fifo_count;
    logic       err_parity;
    logic       err_frame;
    logic       err_overflow;

    ps2_keyboard_rx_if kc_if ();

    ps2_keyboard_rx #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (5000),
        .FIFO_DEPTH      (4),
        .FILTER_REPEAT   (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk_raw),
        .ps2_data     (ps2_data_raw),
        .kc           (kc_if),
        .fifo_count   (fifo_count),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sc;
        bit         flip;
        bit         push;
        logic [9:0] code;
        int         d_par;
        int         d_frm;
    } vec_t;

    vec_t       vecs [10];
    logic [9:0] sb [$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         par_cnt = 0;
    int         frm_cnt = 0;
    int         ovf_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 kc_if.kc_ready = v;
    endtask

    // Device-side frame: data changes mid-high, host samples on the fall.
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_raw = bits[i];
            wait_clk(HALF / 2);
            ps2_clk_raw = 1'b0;
            wait_clk(HALF);
            ps2_clk_raw = 1'b1;
            wait_clk(HALF / 2);
        end
        ps2_data_raw = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        wait_clk(4);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int p0, f0, o0;
        kc_if.kc_ready = 1'b1;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0, 0};
        vecs[1] = '{8'hE0, 1'b0, 1'b0, 10'h000, 0, 0};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, 10'h000, 0, 0};
        vecs[3] = '{8'h74, 1'b0, 1'b1, 10'h374, 0, 0};
        vecs[4] = '{8'hF0, 1'b0, 1'b0, 10'h000, 0, 0};
        vecs[5] = '{8'h1C, 1'b0, 1'b1, 10'h21C, 0, 0};
        vecs[6] = '{8'hE0, 1'b0, 1'b0, 10'h000, 0, 0};
        vecs[7] = '{8'h1C, 1'b1, 1'b0, 10'h000, 1, 0};
        vecs[8] = '{8'hF0, 1'b0, 1'b0, 10'h000, 0, 0};
        vecs[9] = '{8'h1C, 1'b0, 1'b1, 10'h21C, 0, 0};

        // Monitor: error pulse counting and scoreboard comparison on pops.
        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (err_parity)   par_cnt++;
                    if (err_frame)    frm_cnt++;
                    if (err_overflow) ovf_cnt++;
                    if (kc_if.kc_valid && kc_if.kc_ready) begin
                        if (sb.size() == 0) begin
                            check("unexpected_pop", {22'd0, kc_if.kc_data}, 32'hFFFFFFFF);
                        end else begin
                            logic [9:0] e;
                            e = sb.pop_front();
                            check("kc_data", {22'd0, kc_if.kc_data}, {22'd0, e});
                        end
                    end
                end
            end
        join_none

        // Reset state.
        wait_clk(5);
        @(negedge clk);
        check("rst_kc_valid", {31'd0, kc_if.kc_valid}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_errs", {29'd0, err_parity, err_frame, err_overflow}, 32'd0);
        #1 reset = 1'b0;
        wait_clk(20);

        // Table: plain, extended release, release, parity error clearing prefixes.
        for (int i = 0; i < 10; i++) begin
            p0 = par_cnt;
            f0 = frm_cnt;
            if (vecs[i].push) sb.push_back(vecs[i].code);
            send_frame(vecs[i].sc, vecs[i].flip, 11);
            wait_clk(30);
            check($sformatf("vec%0d_err_parity", i), par_cnt - p0, vecs[i].d_par);
            check($sformatf("vec%0d_err_frame", i), frm_cnt - f0, vecs[i].d_frm);
        end
        drain();
        check("table_no_overflow", ovf_cnt, 32'd0);

        // Timeout after 5 bits, then a clean frame.
        p0 = par_cnt;
        f0 = frm_cnt;
        send_frame(8'h1C, 1'b0, 5);
        wait_clk(5300);
        check("timeout_err_frame", frm_cnt - f0, 32'd1);
        check("timeout_no_parity", par_cnt - p0, 32'd0);
        sb.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11);
        wait_clk(30);
        drain();
        check("after_timeout_err_frame", frm_cnt - f0, 32'd1);

        // Release 1C so the held make is forgotten, then fill with kc_ready low.
        sb.push_back(10'h21C);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        wait_clk(30);
        drain();
        set_ready(1'b0);
        o0 = ovf_cnt;
        sb.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        sb.push_back(10'h21C);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
        sb.push_back(10'h032);
        send_frame(8'h32, 1'b0, 11);
        sb.push_back(10'h021);
        send_frame(8'h21, 1'b0, 11);
        wait_clk(30);
        check("fill_fifo_count", {29'd0, fifo_count}, 32'd4);
        check("fill_no_overflow", ovf_cnt - o0, 32'd0);
        check("fill_kc_valid", {31'd0, kc_if.kc_valid}, 32'd1);
        send_frame(8'h22, 1'b0, 11);
        wait_clk(30);
        check("overflow_pulse", ovf_cnt - o0, 32'd1);
        check("overflow_fifo_count", {29'd0, fifo_count}, 32'd4);
        set_ready(1'b1);
        drain();
        @(negedge clk);
        check("popped_fifo_count", {29'd0, fifo_count}, 32'd0);

        // Mid-frame reset with one code held.
        set_ready(1'b0);
        p0 = par_cnt;
        f0 = frm_cnt;
        send_frame(8'h1C, 1'b0, 11);
        wait_clk(30);
        check("pre_reset_fifo_count", {29'd0, fifo_count}, 32'd1);
        send_frame(8'h4B, 1'b0, 3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_kc_valid", {31'd0, kc_if.kc_valid}, 32'd0);
        check("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
        #1 reset = 1'b0;
        wait_clk(300);
        set_ready(1'b1);
        sb.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11);
        wait_clk(30);
        drain();
        check("reset_no_errors", (par_cnt - p0) + (frm_cnt - f0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
